// File: rtl/dffmem_pkg.sv
// Shared types, default sizes and the parity helper for the DFF burst memory.
package dffmem_pkg;

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_t;

    localparam int DEF_DW    = 16;
    localparam int DEF_DEPTH = 8;

    // Widest word the parity helper accepts; callers zero-extend into it.
    localparam int PAR_MAX_W = 256;

    function automatic logic even_par(input logic [PAR_MAX_W-1:0] v);
        return ^v;
    endfunction

endpackage

// File: rtl/dffmem_burst_if.sv
// Command/response bundle between the tile pin wrapper (master) and the memory (slave).
interface dffmem_burst_if
    import dffmem_pkg::*;
#(
    parameter int DW = DEF_DW,
    parameter int AW = $clog2(DEF_DEPTH)
);
    logic          cs;
    logic          addr_ld;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] din;
    logic          par_inj;
    logic [DW-1:0] dout;
    logic          dout_valid;
    logic          busy;
    logic          addr_err;
    logic          par_err;

    modport master (
        output cs, addr_ld, we, addr, din, par_inj,
        input  dout, dout_valid, busy, addr_err, par_err
    );

    modport slave (
        input  cs, addr_ld, we, addr, din, par_inj,
        output dout, dout_valid, busy, addr_err, par_err
    );
endinterface

// File: rtl/dffmem_ptr.sv
// Wrap-around index counter with load, increment and out-of-range load rejection.
module dffmem_ptr
    import dffmem_pkg::*;
#(
    parameter  int DEPTH = DEF_DEPTH,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ld,
    input  logic          inc,
    input  logic [AW-1:0] ld_val,
    output logic [AW-1:0] val,
    output logic          at_last,
    output logic          range_err
);
    localparam logic [AW:0]   DEPTH_W = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);

    assign at_last = (val == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            val       <= '0;
            range_err <= 1'b0;
        end else begin
            range_err <= 1'b0;
            if (ld) begin
                // A rejected load leaves the pointer where it was.
                if ({1'b0, ld_val} < DEPTH_W)
                    val <= ld_val;
                else
                    range_err <= 1'b1;
            end else if (inc) begin
                val <= at_last ? '0 : val + 1'b1;
            end
        end
    end
endmodule

// File: rtl/dffmem_burst.sv
// DFF single-port memory with auto-increment burst pointer and post-reset clear sweep.
// Define DFFMEM_PARITY_EN to store a per-word parity bit and report par_err on reads.
module dffmem_burst
    import dffmem_pkg::*;
#(
    parameter  int DW    = DEF_DW,
    parameter  int DEPTH = DEF_DEPTH,
    localparam int AW    = $clog2(DEPTH)
) (
    input logic           clk,
    input logic           rst,
    dffmem_burst_if.slave bus
);
`ifdef DFFMEM_PARITY_EN
    localparam int MW = DW + 1;
`else
    localparam int MW = DW;
`endif

    state_t        state;
    logic          busy_q;
    logic [DW-1:0] dout_q;
    logic          valid_q;
    logic          perr_q;

    logic [MW-1:0] mem [DEPTH];

    logic [AW-1:0] ptr;
    logic [AW-1:0] clr;
    logic          clr_last;
    logic          unused_ptr_last;
    logic          unused_clr_err;

    logic          cmd, ld_acc, wr_acc, rd_acc;
    logic          wr_en;
    logic [AW-1:0] wr_idx;
    logic [MW-1:0] wr_word;
    logic [MW-1:0] rd_word;
    logic          rd_perr;

    assign cmd    = (state == ST_RUN) && bus.cs;
    assign ld_acc = cmd && bus.addr_ld;
    assign wr_acc = cmd && !bus.addr_ld && bus.we;
    assign rd_acc = cmd && !bus.addr_ld && !bus.we;

    dffmem_ptr #(.DEPTH(DEPTH)) u_ptr (
        .clk       (clk),
        .rst       (rst),
        .ld        (ld_acc),
        .inc       (wr_acc || rd_acc),
        .ld_val    (bus.addr),
        .val       (ptr),
        .at_last   (unused_ptr_last),
        .range_err (bus.addr_err)
    );

    dffmem_ptr #(.DEPTH(DEPTH)) u_clr (
        .clk       (clk),
        .rst       (rst),
        .ld        (1'b0),
        .inc       (state == ST_INIT),
        .ld_val    ('0),
        .val       (clr),
        .at_last   (clr_last),
        .range_err (unused_clr_err)
    );

    always_comb begin
        wr_en   = (state == ST_INIT) || wr_acc;
        wr_idx  = (state == ST_INIT) ? clr : ptr;
        wr_word = '0;
        if (state == ST_RUN) begin
`ifdef DFFMEM_PARITY_EN
            wr_word = {even_par(PAR_MAX_W'(bus.din)) ^ bus.par_inj, bus.din};
`else
            wr_word = bus.din;
`endif
        end
    end

`ifndef DFFMEM_PARITY_EN
    logic unused_par_inj;
    assign unused_par_inj = bus.par_inj;
`endif

    // Storage is cleared by the INIT sweep rather than by reset.
    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_idx] <= wr_word;
    end

    assign rd_word = mem[ptr];

`ifdef DFFMEM_PARITY_EN
    assign rd_perr = rd_word[DW] != even_par(PAR_MAX_W'(rd_word[DW-1:0]));
`else
    assign rd_perr = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_INIT;
            busy_q  <= 1'b1;
            dout_q  <= '0;
            valid_q <= 1'b0;
            perr_q  <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            case (state)
                ST_INIT: begin
                    if (clr_last) begin
                        state  <= ST_RUN;
                        busy_q <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (rd_acc) begin
                        dout_q  <= rd_word[DW-1:0];
                        valid_q <= 1'b1;
                        perr_q  <= rd_perr;
                    end
                end
                default: state <= ST_RUN;
            endcase
        end
    end

    assign bus.dout       = dout_q;
    assign bus.dout_valid = valid_q;
    assign bus.busy       = busy_q;
    assign bus.par_err    = perr_q;
endmodule

// File: tb/tb_dffmem_burst.sv
// Directed bench for dffmem_burst: cycle model for the DEPTH=8 instance, literal checks on both.
// Parity expectations follow DFFMEM_PARITY_EN.
module tb_dffmem_burst;
    logic clk  = 1'b0;
    logic rst  = 1'b0;
    logic rst6 = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    dffmem_burst_if #(.DW(16), .AW(3)) bus  ();
    dffmem_burst_if #(.DW(16), .AW(3)) bus6 ();

    dffmem_burst #(.DW(16), .DEPTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    dffmem_burst #(.DW(16), .DEPTH(6)) dut6 (
        .clk (clk),
        .rst (rst6),
        .bus (bus6)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model of the DEPTH=8 instance: plain array, integer pointer, cycle count.
    logic [15:0] mm [8];
    logic        mp [8];
    int          mcnt = 0;
    int          mptr = 0;
    logic [15:0] e_dout  = '0;
    logic        e_valid = 1'b0;
    logic        e_aerr  = 1'b0;
    logic        e_perr  = 1'b0;
    bit          model_live = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            model_live = 1'b1;
            mcnt = 0; mptr = 0;
            e_dout = '0; e_valid = 1'b0; e_aerr = 1'b0; e_perr = 1'b0;
            for (int i = 0; i < 8; i++) begin
                mm[i] = '0;
                mp[i] = 1'b0;
            end
        end else begin
            e_valid = 1'b0;
            e_aerr  = 1'b0;
            if (mcnt < 8) begin
                mcnt++;
            end else if (bus.cs) begin
                if (bus.addr_ld) begin
                    if (int'(bus.addr) < 8) mptr = int'(bus.addr);
                    else e_aerr = 1'b1;
                end else if (bus.we) begin
                    mm[mptr] = bus.din;
`ifdef DFFMEM_PARITY_EN
                    mp[mptr] = (^bus.din) ^ bus.par_inj;
`else
                    mp[mptr] = 1'b0;
`endif
                    mptr = (mptr + 1) % 8;
                end else begin
                    e_dout  = mm[mptr];
                    e_valid = 1'b1;
`ifdef DFFMEM_PARITY_EN
                    e_perr  = mp[mptr] ^ (^mm[mptr]);
`else
                    e_perr  = 1'b0;
`endif
                    mptr = (mptr + 1) % 8;
                end
            end
        end
    end

    always @(negedge clk) begin
        #2;
        if (model_live) begin
            chk("m_dout",     32'(bus.dout),       32'(e_dout));
            chk("m_valid",    32'(bus.dout_valid), 32'(e_valid));
            chk("m_busy",     32'(bus.busy),       32'(mcnt < 8));
            chk("m_addr_err", 32'(bus.addr_err),   32'(e_aerr));
            chk("m_par_err",  32'(bus.par_err),    32'(e_perr));
        end
    end

    task automatic drv(input logic c, input logic l, input logic w,
                       input logic [2:0] a, input logic [15:0] d, input logic inj);
        @(negedge clk);
        bus.cs = c; bus.addr_ld = l; bus.we = w;
        bus.addr = a; bus.din = d; bus.par_inj = inj;
    endtask

    task automatic drv6(input logic c, input logic l, input logic w,
                        input logic [2:0] a, input logic [15:0] d);
        @(negedge clk);
        bus6.cs = c; bus6.addr_ld = l; bus6.we = w;
        bus6.addr = a; bus6.din = d; bus6.par_inj = 1'b0;
    endtask

    task automatic ld(input logic [2:0] a);      drv(1'b1, 1'b1, 1'b0, a, 16'h0, 1'b0); endtask
    task automatic wr(input logic [15:0] d);     drv(1'b1, 1'b0, 1'b1, 3'd0, d, 1'b0);  endtask
    task automatic wr_inj(input logic [15:0] d); drv(1'b1, 1'b0, 1'b1, 3'd0, d, 1'b1);  endtask
    task automatic rd();                         drv(1'b1, 1'b0, 1'b0, 3'd0, 16'h0, 1'b0); endtask
    task automatic idle();                       drv(1'b0, 1'b0, 1'b0, 3'd0, 16'h0, 1'b0); endtask

    // Pulse reset on one instance, then count cycles with busy high starting at release.
    task automatic do_reset(input bit which, output int n);
        @(negedge clk);
        if (which) rst6 = 1'b1; else rst = 1'b1;
        @(negedge clk);
        #2;
        if (which) chk("rst6_busy", 32'(bus6.busy), 32'd1);
        else begin
            chk("rst_busy",  32'(bus.busy),       32'd1);
            chk("rst_dout",  32'(bus.dout),       32'd0);
            chk("rst_valid", 32'(bus.dout_valid), 32'd0);
        end
        @(negedge clk);
        if (which) begin
            rst6 = 1'b0;
            bus6.cs = 1'b0; bus6.addr_ld = 1'b0; bus6.we = 1'b0;
        end else begin
            rst = 1'b0;
            bus.cs = 1'b0; bus.addr_ld = 1'b0; bus.we = 1'b0; bus.par_inj = 1'b0;
        end
        #2;
        n = 0;
        for (int k = 0; k < 40; k++) begin
            if (which ? !bus6.busy : !bus.busy) break;
            n++;
            @(negedge clk);
            #2;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int nb;
        bus.cs = 1'b0; bus.addr_ld = 1'b0; bus.we = 1'b0;
        bus.addr = '0; bus.din = '0; bus.par_inj = 1'b0;
        bus6.cs = 1'b0; bus6.addr_ld = 1'b0; bus6.we = 1'b0;
        bus6.addr = '0; bus6.din = '0; bus6.par_inj = 1'b0;

        // Reset and clear sweep
        do_reset(1'b0, nb);
        chk("busy_cycles", 32'(nb), 32'd8);

        // Read burst of the whole cleared array
        ld(3'd0);
        for (int i = 0; i < 8; i++) rd();
        idle(); #2;
        chk("clr_last_valid", 32'(bus.dout_valid), 32'd1);
        chk("clr_last_dout",  32'(bus.dout),       32'h0000);

        // Write burst wrapping 6,7,0 then read it back
        ld(3'd6);
        wr(16'h1111); wr(16'h2222); wr(16'h3333);
        ld(3'd6);
        rd();
        rd();   #2; chk("wrap_rd6", 32'(bus.dout), 32'h1111);
        rd();   #2; chk("wrap_rd7", 32'(bus.dout), 32'h2222);
        idle(); #2; chk("wrap_rd0", 32'(bus.dout), 32'h3333);
        chk("wrap_rd0_valid", 32'(bus.dout_valid), 32'd1);

        // Write then reload and read; dout holds while cs is low
        ld(3'd3);
        wr(16'hABCD);
        ld(3'd3);
        rd();
        idle(); #2;
        chk("raw_dout",  32'(bus.dout),       32'hABCD);
        chk("raw_valid", 32'(bus.dout_valid), 32'd1);
        for (int i = 0; i < 4; i++) idle();
        #2;
        chk("hold_dout",  32'(bus.dout),       32'hABCD);
        chk("hold_valid", 32'(bus.dout_valid), 32'd0);

        // Parity: corrupted word at 1, clean word at 2
        ld(3'd1);
        wr_inj(16'h00FF);
        wr(16'h0F0F);
        ld(3'd1);
        rd();
        rd(); #2;
        chk("par_dout", 32'(bus.dout), 32'h00FF);
`ifdef DFFMEM_PARITY_EN
        chk("par_err_inj", 32'(bus.par_err), 32'd1);
`else
        chk("par_err_inj", 32'(bus.par_err), 32'd0);
`endif
        idle(); #2;
        chk("clean_dout",    32'(bus.dout),    32'h0F0F);
        chk("clean_par_err", 32'(bus.par_err), 32'd0);

        // Reset in the middle of a write burst at 2
        ld(3'd2);
        wr(16'h7777); wr(16'h8888);
        drv(1'b1, 1'b0, 1'b1, 3'd0, 16'h9999, 1'b0);
        do_reset(1'b0, nb);
        chk("busy_cycles_2", 32'(nb), 32'd8);
        ld(3'd2);
        rd();
        idle(); #2;
        chk("post_rst_valid", 32'(bus.dout_valid), 32'd1);
        chk("post_rst_dout",  32'(bus.dout),       32'h0000);
        idle(); idle();

        // DEPTH=6 instance: out-of-range load and non-power-of-two wrap
        do_reset(1'b1, nb);
        chk("busy6_cycles", 32'(nb), 32'd6);
        drv6(1'b1, 1'b1, 1'b0, 3'd5, 16'h0);
        drv6(1'b1, 1'b0, 1'b1, 3'd0, 16'hAAAA);
        drv6(1'b1, 1'b0, 1'b1, 3'd0, 16'hBBBB);
        drv6(1'b1, 1'b1, 1'b0, 3'd2, 16'h0);
        drv6(1'b1, 1'b0, 1'b1, 3'd0, 16'h0055);
        drv6(1'b1, 1'b1, 1'b0, 3'd2, 16'h0);
        drv6(1'b1, 1'b1, 1'b0, 3'd6, 16'h0);
        drv6(1'b1, 1'b0, 1'b0, 3'd0, 16'h0); #2;
        chk("aerr6_pulse", 32'(bus6.addr_err), 32'd1);
        drv6(1'b0, 1'b0, 1'b0, 3'd0, 16'h0); #2;
        chk("aerr6_clear", 32'(bus6.addr_err),   32'd0);
        chk("aerr6_dout",  32'(bus6.dout),       32'h0055);
        chk("aerr6_valid", 32'(bus6.dout_valid), 32'd1);
        drv6(1'b1, 1'b1, 1'b0, 3'd5, 16'h0);
        drv6(1'b1, 1'b0, 1'b0, 3'd0, 16'h0);
        drv6(1'b1, 1'b0, 1'b0, 3'd0, 16'h0); #2;
        chk("wrap6_rd5", 32'(bus6.dout), 32'hAAAA);
        drv6(1'b0, 1'b0, 1'b0, 3'd0, 16'h0); #2;
        chk("wrap6_rd0", 32'(bus6.dout), 32'hBBBB);
        chk("wrap6_aerr", 32'(bus6.addr_err), 32'd0);
        drv6(1'b0, 1'b0, 1'b0, 3'd0, 16'h0);

        @(negedge clk);
        #3;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
